// File: rtl/mio_bus_master.sv
// ============================================================================
// mio_bus_master : block-copy DMA initiator sharing the MIO bus with the CPU
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mio_bus_master #(
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             src_inc_i,
  input  logic             dst_inc_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [LEN_W-1:0] words_done_o,
  output logic             bus_req_o,
  input  logic             bus_gnt_i,
  output logic [31:0]      addr_bus_o,
  output logic             mem_w_o,
  output logic [31:0]      Cpu_data2bus_o,
  input  logic [31:0]      Cpu_data4bus_i
);

  localparam int C_RDW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
  localparam int C_BW  = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_REL  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [31:0]      data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] words_q, words_d;
  logic [C_BW-1:0]  burst_q, burst_d;
  logic [C_RDW-1:0] rdc_q, rdc_d;
  logic             src_inc_q, src_inc_d;
  logic             dst_inc_q, dst_inc_d;
  logic             aborted_q, aborted_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      rem_q     <= '0;
      words_q   <= '0;
      burst_q   <= '0;
      rdc_q     <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      words_q   <= words_d;
      burst_q   <= burst_d;
      rdc_q     <= rdc_d;
      src_inc_q <= src_inc_d;
      dst_inc_q <= dst_inc_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    data_d         = data_q;
    rem_d          = rem_q;
    words_d        = words_q;
    burst_d        = burst_q;
    rdc_d          = rdc_q;
    src_inc_d      = src_inc_q;
    dst_inc_d      = dst_inc_q;
    aborted_d      = aborted_q;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    bus_req_o      = 1'b0;
    addr_bus_o     = '0;
    mem_w_o        = 1'b0;
    Cpu_data2bus_o = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d     = src_addr_i & ~32'd3;
          dst_d     = dst_addr_i & ~32'd3;
          rem_d     = len_i;
          src_inc_d = src_inc_i;
          dst_inc_d = dst_inc_i;
          words_d   = '0;
          aborted_d = 1'b0;
          burst_d   = '0;
          state_d   = (len_i != '0) ? S_REQ : S_DONE;
        end
      end

      S_REQ: begin
        busy_o    = 1'b1;
        bus_req_o = 1'b1;
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (bus_gnt_i) begin
          rdc_d   = '0;
          state_d = S_RD;
        end
      end

      // A grant loss mid-read throws the partial read away; the same word is re-read.
      S_RD: begin
        busy_o    = 1'b1;
        bus_req_o = 1'b1;
        if (bus_gnt_i) begin
          addr_bus_o = src_q;
        end
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (!bus_gnt_i) begin
          rdc_d   = '0;
          state_d = S_REQ;
        end else if (rdc_q == C_RDW'(READ_LAT)) begin
          data_d  = Cpu_data4bus_i;
          state_d = S_WR;
        end else begin
          rdc_d = rdc_q + C_RDW'(1);
        end
      end

      S_WR: begin
        busy_o         = 1'b1;
        bus_req_o      = 1'b1;
        addr_bus_o     = dst_q;
        mem_w_o        = 1'b1;
        Cpu_data2bus_o = data_q;
        words_d        = words_q + LEN_W'(1);
        rem_d          = rem_q - LEN_W'(1);
        burst_d        = burst_q + C_BW'(1);
        rdc_d          = '0;
        if (src_inc_q) src_d = src_q + 32'd4;
        if (dst_inc_q) dst_d = dst_q + 32'd4;
        if (rem_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end else if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (burst_d == C_BW'(MAX_BURST)) begin
          state_d = S_REL;
        end else begin
          state_d = S_RD;
        end
      end

      S_REL: begin
        busy_o  = 1'b1;
        burst_d = '0;
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign words_done_o = words_q;
  assign aborted_o    = aborted_q;

endmodule

`default_nettype wire
